// File: rtl/dlx_pkg.sv
// Shared types and constants for the DLX pipeline control slice.
// Imported by the hazard controller and its forwarding sub-unit.
package dlx_pkg;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } ctrl_state_t;

    localparam int REG_ZERO = 0;

endpackage

// File: rtl/dlx_pipe_ctrl_fwd.sv
// Operand forwarding select for one EX source, computed while the
// instruction is still in ID from the EX/MEM shadow destination info.
module dlx_fwd_unit
    import dlx_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] src_i,
    input  logic             used_i,
    input  logic             ex_valid_i,
    input  logic             ex_wr_i,
    input  logic             ex_load_i,
    input  logic [REG_W-1:0] ex_rd_i,
    input  logic             mem_valid_i,
    input  logic             mem_wr_i,
    input  logic [REG_W-1:0] mem_rd_i,
    output fwd_sel_t         sel_o
);

    logic ex_hit;
    logic mem_hit;

    // A load still in EX cannot forward from EX/MEM; load-use stalls it.
    assign ex_hit = ex_valid_i & ex_wr_i & ~ex_load_i
                  & (ex_rd_i != REG_W'(REG_ZERO))
                  & (ex_rd_i == src_i);

    assign mem_hit = mem_valid_i & mem_wr_i
                   & (mem_rd_i != REG_W'(REG_ZERO))
                   & (mem_rd_i == src_i);

    always_comb begin
        sel_o = FWD_RF;
        if (used_i) begin
            if (ex_hit) begin
                sel_o = FWD_EXMEM;
            end else if (mem_hit) begin
                sel_o = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/dlx_pipe_ctrl.sv
// DLX 5-stage hazard/sequencing controller: stalls, flushes, freezes
// and registered forwarding selects from a shadow of EX/MEM dest info.
module dlx_pipe_ctrl
    import dlx_pkg::*;
#(
    parameter int REG_W  = 5,
    parameter int PERF_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_rs1,
    input  logic [REG_W-1:0]  id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_W-1:0]  id_rd,
    input  logic              id_reg_write,
    input  logic              id_load,
    input  logic              id_store,
    input  logic              id_jump,
    input  logic              ex_branch_taken,
    input  logic              dmem_ready,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_write,
    output logic              idex_bubble,
    output logic              exmem_write,
    output logic              memwb_bubble,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [PERF_W-1:0] stall_cycles
);

    logic             ex_valid_q, ex_wr_q, ex_load_q, ex_mem_q;
    logic [REG_W-1:0] ex_rd_q;
    logic             mem_valid_q, mem_wr_q, mem_mem_q;
    logic [REG_W-1:0] mem_rd_q;

    ctrl_state_t       state_q, state_d;
    fwd_sel_t          fwd_a_q, fwd_b_q;
    fwd_sel_t          sel_a, sel_b;
    logic [PERF_W-1:0] stall_q;

    logic freeze, branch, load_use, jump;
    logic rs1_hit, rs2_hit;

    assign freeze = mem_valid_q & mem_mem_q & ~dmem_ready;
    assign branch = ex_valid_q & ex_branch_taken;
    assign jump   = id_valid & id_jump;

    assign rs1_hit = id_rs1_used & (id_rs1 == ex_rd_q);
    assign rs2_hit = id_rs2_used & (id_rs2 == ex_rd_q);

    assign load_use = ex_valid_q & ex_load_q
                    & (ex_rd_q != REG_W'(REG_ZERO))
                    & (rs1_hit | rs2_hit);

    dlx_fwd_unit #(.REG_W(REG_W)) u_fwd_a (
        .src_i       (id_rs1),
        .used_i      (id_rs1_used),
        .ex_valid_i  (ex_valid_q),
        .ex_wr_i     (ex_wr_q),
        .ex_load_i   (ex_load_q),
        .ex_rd_i     (ex_rd_q),
        .mem_valid_i (mem_valid_q),
        .mem_wr_i    (mem_wr_q),
        .mem_rd_i    (mem_rd_q),
        .sel_o       (sel_a)
    );

    dlx_fwd_unit #(.REG_W(REG_W)) u_fwd_b (
        .src_i       (id_rs2),
        .used_i      (id_rs2_used),
        .ex_valid_i  (ex_valid_q),
        .ex_wr_i     (ex_wr_q),
        .ex_load_i   (ex_load_q),
        .ex_rd_i     (ex_rd_q),
        .mem_valid_i (mem_valid_q),
        .mem_wr_i    (mem_wr_q),
        .mem_rd_i    (mem_rd_q),
        .sel_o       (sel_b)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:      if (freeze) state_d = MEM_WAIT;
            MEM_WAIT: if (dmem_ready) state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_write   = 1'b1;
        idex_bubble  = 1'b0;
        exmem_write  = 1'b1;
        memwb_bubble = 1'b0;
        if (!reset_n) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (freeze) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            memwb_bubble = 1'b1;
        end else if (branch) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end else if (jump) begin
            ifid_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RUN;
            ex_valid_q  <= 1'b0;
            ex_wr_q     <= 1'b0;
            ex_load_q   <= 1'b0;
            ex_mem_q    <= 1'b0;
            ex_rd_q     <= '0;
            mem_valid_q <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_mem_q   <= 1'b0;
            mem_rd_q    <= '0;
            fwd_a_q     <= FWD_RF;
            fwd_b_q     <= FWD_RF;
            stall_q     <= '0;
        end else begin
            state_q <= state_d;
            if (!pc_write) begin
                stall_q <= stall_q + 1'b1;
            end
            if (!freeze) begin
                mem_valid_q <= ex_valid_q;
                mem_wr_q    <= ex_wr_q;
                mem_mem_q   <= ex_mem_q;
                mem_rd_q    <= ex_rd_q;
                if (idex_bubble || !id_valid) begin
                    ex_valid_q <= 1'b0;
                    ex_wr_q    <= 1'b0;
                    ex_load_q  <= 1'b0;
                    ex_mem_q   <= 1'b0;
                    ex_rd_q    <= '0;
                    fwd_a_q    <= FWD_RF;
                    fwd_b_q    <= FWD_RF;
                end else begin
                    ex_valid_q <= 1'b1;
                    ex_wr_q    <= id_reg_write;
                    ex_load_q  <= id_load;
                    ex_mem_q   <= id_load | id_store;
                    ex_rd_q    <= id_rd;
                    fwd_a_q    <= sel_a;
                    fwd_b_q    <= sel_b;
                end
            end
        end
    end

    assign fwd_a        = fwd_a_q;
    assign fwd_b        = fwd_b_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_dlx_pipe_ctrl.sv
// Directed bench for dlx_pipe_ctrl: hazards, forwarding, freeze, reset.
// Inputs change #1 after posedge; outputs are sampled on negedge.
module tb_dlx_pipe_ctrl;

    localparam logic [6:0] NORM = 7'b1101010;
    localparam logic [6:0] RST  = 7'b0011110;
    localparam logic [6:0] FRZ  = 7'b0000001;
    localparam logic [6:0] BR   = 7'b1111110;
    localparam logic [6:0] LU   = 7'b0001110;
    localparam logic [6:0] JMP  = 7'b1111010;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        id_valid, id_rs1_used, id_rs2_used;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_reg_write, id_load, id_store, id_jump;
    logic        ex_branch_taken, dmem_ready;
    logic        pc_write, ifid_write, ifid_flush, idex_write;
    logic        idex_bubble, exmem_write, memwb_bubble;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cycles;
    logic [6:0]  ctl;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dlx_pipe_ctrl dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rs1_used     (id_rs1_used),
        .id_rs2_used     (id_rs2_used),
        .id_rd           (id_rd),
        .id_reg_write    (id_reg_write),
        .id_load         (id_load),
        .id_store        (id_store),
        .id_jump         (id_jump),
        .ex_branch_taken (ex_branch_taken),
        .dmem_ready      (dmem_ready),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_write      (idex_write),
        .idex_bubble     (idex_bubble),
        .exmem_write     (exmem_write),
        .memwb_bubble    (memwb_bubble),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b),
        .stall_cycles    (stall_cycles)
    );

    assign ctl = {pc_write, ifid_write, ifid_flush, idex_write,
                  idex_bubble, exmem_write, memwb_bubble};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic id_set(input logic v, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic u1,
                          input logic u2, input logic [4:0] rd,
                          input logic wr, input logic ld,
                          input logic st, input logic jmp);
        id_valid     = v;
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_rs1_used  = u1;
        id_rs2_used  = u2;
        id_rd        = rd;
        id_reg_write = wr;
        id_load      = ld;
        id_store     = st;
        id_jump      = jmp;
    endtask

    task automatic id_idle;
        id_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic next_cyc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        ex_branch_taken = 1'b0;
        dmem_ready = 1'b1;
        id_idle();
        @(negedge clk);
        check("rst_ctl", 32'(ctl), 32'(RST));
        check("rst_fwd", {fwd_a, fwd_b}, 0);
        check("rst_cnt", 32'(stall_cycles), 0);
        next_cyc();
        reset_n = 1'b1;

        // A: ADD r3,r1,r2
        id_set(1, 1, 2, 1, 1, 3, 1, 0, 0, 0);
        @(negedge clk); check("A_ctl", 32'(ctl), 32'(NORM));
        next_cyc();
        // B: SUB r4,r3,r5
        id_set(1, 3, 5, 1, 1, 4, 1, 0, 0, 0);
        @(negedge clk); check("B_ctl", 32'(ctl), 32'(NORM));
        check("B_fwda", 32'(fwd_a), 0);
        next_cyc();
        // C: OR r6,r0,r3 ; SUB now in EX
        id_set(1, 0, 3, 1, 1, 6, 1, 0, 0, 0);
        @(negedge clk);
        check("C_fwda_exmem", 32'(fwd_a), 1);
        check("C_fwdb", 32'(fwd_b), 0);
        next_cyc();
        // D: ADD r0,r1,r2 ; OR in EX reads r3 from MEM/WB
        id_set(1, 1, 2, 1, 1, 0, 1, 0, 0, 0);
        @(negedge clk);
        check("D_fwdb_memwb", 32'(fwd_b), 2);
        check("D_fwda", 32'(fwd_a), 0);
        next_cyc();
        // E: ADD r9,r0,r0
        id_set(1, 0, 0, 1, 1, 9, 1, 0, 0, 0);
        @(negedge clk); check("E_ctl", 32'(ctl), 32'(NORM));
        next_cyc();
        // F: LW r7,0(r1) ; r0 writer must not forward
        id_set(1, 1, 0, 1, 0, 7, 1, 1, 0, 0);
        @(negedge clk);
        check("F_r0_fwd", {fwd_a, fwd_b}, 0);
        check("F_ctl", 32'(ctl), 32'(NORM));
        next_cyc();
        // G: ADD r8,r7,r0 -> load-use
        id_set(1, 7, 0, 1, 1, 8, 1, 0, 0, 0);
        @(negedge clk);
        check("G_ld_use", 32'(ctl), 32'(LU));
        check("G_cnt", 32'(stall_cycles), 0);
        next_cyc();
        // H: ADD held in ID
        @(negedge clk);
        check("H_ctl", 32'(ctl), 32'(NORM));
        check("H_cnt", 32'(stall_cycles), 1);
        check("H_fwd_bub", {fwd_a, fwd_b}, 0);
        next_cyc();
        // I: LW r9,0(r1) ; ADD in EX gets load data via MEM/WB
        id_set(1, 1, 0, 1, 0, 9, 1, 1, 0, 0);
        @(negedge clk);
        check("I_fwda_ld", 32'(fwd_a), 2);
        check("I_ctl", 32'(ctl), 32'(NORM));
        next_cyc();
        // J: ADDI r2,r9,4 (rs2 field=r9 unused)
        id_set(1, 9, 9, 1, 0, 2, 1, 0, 0, 0);
        @(negedge clk); check("J_ld_use", 32'(ctl), 32'(LU));
        next_cyc();
        @(negedge clk);
        check("K_ctl", 32'(ctl), 32'(NORM));
        check("K_cnt", 32'(stall_cycles), 2);
        next_cyc();
        // L: LW r9,0(r1)
        id_set(1, 1, 0, 1, 0, 9, 1, 1, 0, 0);
        @(negedge clk); check("L_fwda", 32'(fwd_a), 2);
        next_cyc();
        // M: ADDI r2,r5,4 with unused rs2=r9 -> no stall
        id_set(1, 5, 9, 1, 0, 2, 1, 0, 0, 0);
        @(negedge clk); check("M_no_stall", 32'(ctl), 32'(NORM));
        next_cyc();
        // N: BEQZ r1
        id_set(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk); check("N_fwd", {fwd_a, fwd_b}, 0);
        next_cyc();
        // O: JAL (r31) in ID while BEQZ taken in EX
        id_set(1, 0, 0, 0, 0, 31, 1, 0, 0, 1);
        ex_branch_taken = 1'b1;
        @(negedge clk); check("O_branch", 32'(ctl), 32'(BR));
        next_cyc();
        // P: ADD r1,r31,r0 ; discarded JAL must not forward
        ex_branch_taken = 1'b0;
        id_set(1, 31, 0, 1, 1, 1, 1, 0, 0, 0);
        @(negedge clk); check("P_ctl", 32'(ctl), 32'(NORM));
        next_cyc();
        // Q: JAL r31, no branch
        id_set(1, 0, 0, 0, 0, 31, 1, 0, 0, 1);
        @(negedge clk);
        check("Q_jal_gone", 32'(fwd_a), 0);
        check("Q_jump", 32'(ctl), 32'(JMP));
        next_cyc();
        // R: ADD r11,r31,r0
        id_set(1, 31, 0, 1, 1, 11, 1, 0, 0, 0);
        @(negedge clk); check("R_ctl", 32'(ctl), 32'(NORM));
        next_cyc();
        // S: SW r2,0(r1)
        id_set(1, 1, 2, 1, 1, 0, 0, 0, 1, 0);
        @(negedge clk); check("S_fwda_jal", 32'(fwd_a), 1);
        next_cyc();
        // T: BEQZ r11
        id_set(1, 11, 0, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk); check("T_ctl", 32'(ctl), 32'(NORM));
        next_cyc();
        // U..W: SW in MEM waits 3 cycles, branch held in EX
        id_set(1, 6, 7, 1, 1, 5, 1, 0, 0, 0);
        dmem_ready = 1'b0;
        ex_branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("frz%0d_ctl", i), 32'(ctl), 32'(FRZ));
            check($sformatf("frz%0d_fwd", i), 32'(fwd_a), 2);
            check($sformatf("frz%0d_cnt", i), 32'(stall_cycles), 2 + i);
            next_cyc();
        end
        // X: release; held branch taken
        dmem_ready = 1'b1;
        @(negedge clk);
        check("X_branch", 32'(ctl), 32'(BR));
        check("X_cnt", 32'(stall_cycles), 5);
        next_cyc();
        ex_branch_taken = 1'b0;
        id_idle();
        @(negedge clk); check("Y_ctl", 32'(ctl), 32'(NORM));
        next_cyc();
        // Z: SW, then reset during MEM_WAIT
        id_set(1, 1, 2, 1, 1, 0, 0, 0, 1, 0);
        next_cyc();
        id_idle();
        next_cyc();
        dmem_ready = 1'b0;
        @(negedge clk); check("AB_frz", 32'(ctl), 32'(FRZ));
        next_cyc();
        @(negedge clk); check("AC_cnt", 32'(stall_cycles), 6);
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_ctl", 32'(ctl), 32'(RST));
        check("mid_rst_cnt", 32'(stall_cycles), 0);
        check("mid_rst_fwd", {fwd_a, fwd_b}, 0);
        next_cyc();
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_ctl", 32'(ctl), 32'(NORM));
        check("post_rst_cnt", 32'(stall_cycles), 0);
        next_cyc();
        dmem_ready = 1'b1;
        @(negedge clk);
        check("post_rst_cnt2", 32'(stall_cycles), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
